// File: rtl/mac_vec.sv
// Variable-length dot-product unit: accumulates a*b over a val/rdy operand stream
// and emits {ovf, result} after the term flagged 'last'.
module mac_vec #(
    parameter int p_width  = 16,
    parameter int p_signed = 0,
    parameter int p_sat    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_width:0]   req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_width:0]     resp_msg
);

    // Two guard bits above the double-width product keep acc + a*b exact in both modes.
    localparam int W2 = 2 * p_width + 2;

    localparam logic signed [W2-1:0] HI_BOUND = (p_signed != 0)
        ? {{(W2-p_width+1){1'b0}}, {(p_width-1){1'b1}}}
        : {{(W2-p_width){1'b0}}, {p_width{1'b1}}};
    localparam logic signed [W2-1:0] LO_BOUND = (p_signed != 0)
        ? {{(W2-p_width+1){1'b1}}, {(p_width-1){1'b0}}}
        : {W2{1'b0}};
    localparam logic [p_width-1:0] SAT_HI = (p_signed != 0)
        ? {1'b0, {(p_width-1){1'b1}}}
        : {p_width{1'b1}};
    localparam logic [p_width-1:0] SAT_LO = (p_signed != 0)
        ? {1'b1, {(p_width-1){1'b0}}}
        : {p_width{1'b0}};

    typedef enum logic {ACC, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [p_width-1:0]   acc;
    logic [p_width-1:0]   acc_next;
    logic                 ovf;
    logic                 ovf_next;

    logic                 req_last;
    logic [p_width-1:0]   req_a;
    logic [p_width-1:0]   req_b;
    logic                 req_fire;
    logic                 resp_fire;

    logic                 a_sx;
    logic                 b_sx;
    logic                 acc_sx;
    logic signed [W2-1:0] a_ext;
    logic signed [W2-1:0] b_ext;
    logic signed [W2-1:0] acc_ext;
    logic signed [W2-1:0] prod;
    logic signed [W2-1:0] total;
    logic                 above;
    logic                 below;

    assign req_last  = req_msg[2*p_width];
    assign req_a     = req_msg[2*p_width-1:p_width];
    assign req_b     = req_msg[p_width-1:0];
    assign req_fire  = req_val & req_rdy;
    assign resp_fire = resp_val & resp_rdy;

    // Extension bit is the MSB only when operands are two's complement.
    assign a_sx   = (p_signed != 0) ? req_a[p_width-1] : 1'b0;
    assign b_sx   = (p_signed != 0) ? req_b[p_width-1] : 1'b0;
    assign acc_sx = (p_signed != 0) ? acc[p_width-1]   : 1'b0;

    assign a_ext   = {{(W2-p_width){a_sx}}, req_a};
    assign b_ext   = {{(W2-p_width){b_sx}}, req_b};
    assign acc_ext = {{(W2-p_width){acc_sx}}, acc};
    assign prod    = a_ext * b_ext;
    assign total   = acc_ext + prod;
    assign above   = total > HI_BOUND;
    assign below   = total < LO_BOUND;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (req_fire && req_last) state_next = DONE;
            DONE:    if (resp_fire) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_comb begin
        req_rdy  = !reset && (state == ACC);
        resp_val = !reset && (state == DONE);
    end

    assign resp_msg = {ovf, acc};

    // Range check and clamp/wrap happen on every term, so the result is order-dependent.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf;
        if (req_fire) begin
            if (above) begin
                ovf_next = 1'b1;
                acc_next = (p_sat != 0) ? SAT_HI : total[p_width-1:0];
            end else if (below) begin
                ovf_next = 1'b1;
                acc_next = (p_sat != 0) ? SAT_LO : total[p_width-1:0];
            end else begin
                acc_next = total[p_width-1:0];
            end
        end else if (resp_fire) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mac_vec.sv
// Directed and randomised checks of mac_vec across all four signed/saturate
// configurations, driven in lockstep from one shared stimulus stream.
module tb_mac_vec;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic [32:0] req_msg;
    logic        resp_rdy;

    logic        rdy_uw, rdy_us, rdy_sw, rdy_ss;
    logic        val_uw, val_us, val_sw, val_ss;
    logic [16:0] msg_uw, msg_us, msg_sw, msg_ss;

    int checks;
    int errors;
    int cycle_cnt;

    mac_vec #(.p_width(16), .p_signed(0), .p_sat(0)) u_uw (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(rdy_uw), .req_msg(req_msg),
        .resp_val(val_uw), .resp_rdy(resp_rdy), .resp_msg(msg_uw));
    mac_vec #(.p_width(16), .p_signed(0), .p_sat(1)) u_us (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(rdy_us), .req_msg(req_msg),
        .resp_val(val_us), .resp_rdy(resp_rdy), .resp_msg(msg_us));
    mac_vec #(.p_width(16), .p_signed(1), .p_sat(0)) u_sw (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(rdy_sw), .req_msg(req_msg),
        .resp_val(val_sw), .resp_rdy(resp_rdy), .resp_msg(msg_sw));
    mac_vec #(.p_width(16), .p_signed(1), .p_sat(1)) u_ss (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(rdy_ss), .req_msg(req_msg),
        .resp_val(val_ss), .resp_rdy(resp_rdy), .resp_msg(msg_ss));

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: sim time expired, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Presents one term and returns at the falling edge after it has been accepted.
    task automatic send_term(input logic last, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        req_val = 1'b1;
        req_msg = {last, a, b};
        while (rdy_uw !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("[TB] FAIL send_term timeout: req_rdy=%b required 1", rdy_uw);
        end
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic pop_resp();
        resp_rdy = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [16:0] model_step(input logic [16:0] st, input logic [15:0] a,
                                               input logic [15:0] b, input bit sgn, input bit sat);
        longint acc_v, av, bv, t, lo, hi;
        logic [15:0] r;
        logic o;
        if (sgn) begin
            acc_v = longint'($signed(st[15:0]));
            av = longint'($signed(a));
            bv = longint'($signed(b));
            lo = -32768;
            hi = 32767;
        end else begin
            acc_v = longint'(st[15:0]);
            av = longint'(a);
            bv = longint'(b);
            lo = 0;
            hi = 65535;
        end
        t = acc_v + av * bv;
        o = st[16];
        r = t[15:0];
        if (t > hi) begin
            o = 1'b1;
            if (sat) r = hi[15:0];
        end else if (t < lo) begin
            o = 1'b1;
            if (sat) r = lo[15:0];
        end
        return {o, r};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rdy_uw, rdy_us, rdy_sw, rdy_ss, val_uw, val_us, val_sw, val_ss} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_hold: rdy=%b%b%b%b val=%b%b%b%b required all 0",
                     rdy_uw, rdy_us, rdy_sw, rdy_ss, val_uw, val_us, val_sw, val_ss);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy_uw, rdy_us, rdy_sw, rdy_ss} !== 4'hF || val_uw !== 1'b0 || msg_uw !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_release: rdy=%b%b%b%b val=%b msg=%h required rdy=1111 val=0 msg=0",
                     rdy_uw, rdy_us, rdy_sw, rdy_ss, val_uw, msg_uw);
        end
    endtask

    task automatic test_basic();
        send_term(1'b0, 16'd5, 16'd10);
        send_term(1'b0, 16'd2, 16'd4);
        send_term(1'b0, 16'd4, 16'd8);
        send_term(1'b1, 16'd2, 16'd1);
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd92}) begin
            errors++;
            $display("[TB] FAIL basic_92: val=%b msg=%h required val=1 msg=%h", val_uw, msg_uw, {1'b0, 16'd92});
        end
        pop_resp();
        send_term(1'b0, 16'd10, 16'd10);
        send_term(1'b0, 16'd8, 16'd8);
        send_term(1'b0, 16'd0, 16'd0);
        send_term(1'b1, 16'd0, 16'd91);
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd164}) begin
            errors++;
            $display("[TB] FAIL basic_164: val=%b msg=%h required val=1 msg=%h", val_uw, msg_uw, {1'b0, 16'd164});
        end
        pop_resp();
    endtask

    task automatic test_back_to_back();
        int start;
        resp_rdy = 1'b1;
        start = cycle_cnt;
        send_term(1'b1, 16'd3, 16'd7);
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd21}) begin
            errors++;
            $display("[TB] FAIL single_term: val=%b msg=%h required val=1 msg=%h", val_uw, msg_uw, {1'b0, 16'd21});
        end
        pop_resp();
        for (int i = 0; i < 4; i++) send_term(i == 3, 16'd0, 16'd0);
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== 17'd0) begin
            errors++;
            $display("[TB] FAIL zero_vector: val=%b msg=%h required val=1 msg=0", val_uw, msg_uw);
        end
        pop_resp();
        checks++;
        if (cycle_cnt - start !== 7) begin
            errors++;
            $display("[TB] FAIL b2b_cycles: got %0d cycles required 7", cycle_cnt - start);
        end
    endtask

    task automatic test_overflow();
        send_term(1'b0, 16'd256, 16'd256);
        send_term(1'b1, 16'd1, 16'd1);
        checks++;
        if ({val_uw, val_us, val_sw, val_ss} !== 4'hF) begin
            errors++;
            $display("[TB] FAIL ovf_valid: val=%b%b%b%b required 1111", val_uw, val_us, val_sw, val_ss);
        end
        checks++;
        if (msg_uw !== 17'h1_0001) begin
            errors++;
            $display("[TB] FAIL ovf_wrap: msg=%h required 10001", msg_uw);
        end
        checks++;
        if (msg_us !== 17'h1_FFFF) begin
            errors++;
            $display("[TB] FAIL ovf_sat: msg=%h required 1ffff", msg_us);
        end
        checks++;
        if (msg_sw !== 17'h1_0001 || msg_ss !== 17'h1_7FFF) begin
            errors++;
            $display("[TB] FAIL ovf_signed: wrap=%h sat=%h required 10001 17fff", msg_sw, msg_ss);
        end
        pop_resp();
    endtask

    task automatic test_signed();
        send_term(1'b0, 16'hFFFD, 16'd5);
        send_term(1'b1, 16'd2, 16'd2);
        checks++;
        if (msg_sw !== 17'h0_FFF5 || msg_ss !== 17'h0_FFF5) begin
            errors++;
            $display("[TB] FAIL signed_neg11: wrap=%h sat=%h required 0fff5", msg_sw, msg_ss);
        end
        checks++;
        if (msg_uw !== 17'h1_FFF5 || msg_us !== 17'h1_FFFF) begin
            errors++;
            $display("[TB] FAIL unsigned_big: wrap=%h sat=%h required 1fff5 1ffff", msg_uw, msg_us);
        end
        pop_resp();
        send_term(1'b0, 16'h8000, 16'd1);
        send_term(1'b1, 16'hFFFF, 16'd1);
        checks++;
        if (msg_ss !== 17'h1_8000) begin
            errors++;
            $display("[TB] FAIL signed_sat_min: msg=%h required 18000", msg_ss);
        end
        checks++;
        if (msg_sw !== 17'h1_7FFF) begin
            errors++;
            $display("[TB] FAIL signed_wrap_min: msg=%h required 17fff", msg_sw);
        end
        pop_resp();
    endtask

    task automatic test_backpressure();
        send_term(1'b1, 16'd2, 16'd3);
        resp_rdy = 1'b0;
        req_val = 1'b1;
        req_msg = {1'b1, 16'd4, 16'd5};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy_uw !== 1'b0 || val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd6}) begin
                errors++;
                $display("[TB] FAIL stall_%0d: rdy=%b val=%b msg=%h required rdy=0 val=1 msg=6",
                         i, rdy_uw, val_uw, msg_uw);
            end
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_uw !== 1'b1 || val_uw !== 1'b0 || msg_uw !== 17'd0) begin
            errors++;
            $display("[TB] FAIL stall_release: rdy=%b val=%b msg=%h required rdy=1 val=0 msg=0",
                     rdy_uw, val_uw, msg_uw);
        end
        @(negedge clk);
        req_val = 1'b0;
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd20}) begin
            errors++;
            $display("[TB] FAIL after_stall: val=%b msg=%h required val=1 msg=14", val_uw, msg_uw);
        end
        pop_resp();
    endtask

    task automatic test_reset_mid();
        send_term(1'b0, 16'd7, 16'd7);
        send_term(1'b0, 16'd1, 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_uw !== 1'b1 || msg_uw !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_clear: rdy=%b msg=%h required rdy=1 msg=0", rdy_uw, msg_uw);
        end
        send_term(1'b1, 16'd1, 16'd1);
        checks++;
        if (val_uw !== 1'b1 || msg_uw !== {1'b0, 16'd1}) begin
            errors++;
            $display("[TB] FAIL reset_mid_result: val=%b msg=%h required val=1 msg=1", val_uw, msg_uw);
        end
        pop_resp();
        send_term(1'b1, 16'd5, 16'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (val_uw !== 1'b0 || rdy_uw !== 1'b1 || msg_uw !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_done: val=%b rdy=%b msg=%h required val=0 rdy=1 msg=0",
                     val_uw, rdy_uw, msg_uw);
        end
    endtask

    task automatic test_random();
        logic [16:0] e_uw, e_us, e_sw, e_ss;
        logic [7:0]  a8, b8;
        logic [15:0] a, b;
        int len;
        for (int v = 0; v < 100; v++) begin
            e_uw = '0; e_us = '0; e_sw = '0; e_ss = '0;
            len = $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                a = {{8{a8[7]}}, a8};
                b = {{8{b8[7]}}, b8};
                e_uw = model_step(e_uw, a, b, 1'b0, 1'b0);
                e_us = model_step(e_us, a, b, 1'b0, 1'b1);
                e_sw = model_step(e_sw, a, b, 1'b1, 1'b0);
                e_ss = model_step(e_ss, a, b, 1'b1, 1'b1);
                send_term(t == len - 1, a, b);
            end
            checks++;
            if ({val_uw, val_us, val_sw, val_ss} !== 4'hF || msg_uw !== e_uw || msg_us !== e_us
                || msg_sw !== e_sw || msg_ss !== e_ss) begin
                errors++;
                $display("[TB] FAIL random_%0d: val=%b%b%b%b got %h %h %h %h required %h %h %h %h",
                         v, val_uw, val_us, val_sw, val_ss, msg_uw, msg_us, msg_sw, msg_ss,
                         e_uw, e_us, e_sw, e_ss);
            end
            pop_resp();
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        req_val = 1'b0;
        req_msg = '0;
        resp_rdy = 1'b1;
        checks = 0;
        errors = 0;
        cycle_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
